// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus arbiter: bus addresses, baud
// divisors for a 50 MHz clock, and the arbiter state encoding.
package spart_pkg;

   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   // clk / (16 * baud) - 1 at 50 MHz
   localparam logic [15:0] DIV_4800  = 16'h028A;
   localparam logic [15:0] DIV_9600  = 16'h0144;
   localparam logic [15:0] DIV_19200 = 16'h00A1;
   localparam logic [15:0] DIV_38400 = 16'h0050;

   // Wide enough to index up to four requesters.
   localparam int PTR_W = 2;

   typedef enum logic [2:0] {
      CFG_HI = 3'd0,
      CFG_LO = 3'd1,
      IDLE   = 3'd2,
      ACCESS = 3'd3,
      DONE   = 3'd4
   } arb_state_t;

   function automatic logic [15:0] div_for_cfg(input logic [1:0] cfg);
      case (cfg)
         2'b00:   return DIV_4800;
         2'b01:   return DIV_9600;
         2'b10:   return DIV_19200;
         default: return DIV_38400;
      endcase
   endfunction

endpackage

// File: rtl/spart_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: grants the first requester at or
// after the pointer, wrapping modulo NREQ.
module rr_picker
   import spart_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic             valid_o
);

   // Scan offsets from the pointer; the first hit wins.
   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!valid_o && req_i[j] && (j == ((int'(ptr_i) + k) % NREQ))) begin
               gnt_o[j] = 1'b1;
               valid_o  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spart_bus_arbiter.sv
// SPART processor-side bus arbiter. Programs the baud divisor after reset
// and on every br_cfg change, then shares the bus round-robin between
// requesters, one access per grant. Every output comes straight from a
// flop, so the bus cycle a state produces appears in the following cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   CFG_HI | write divisor high byte (ioaddr 11), latch br_cfg
//   CFG_LO | write divisor low byte (ioaddr 10) for the latched br_cfg
//   IDLE   | reprogram on br_cfg change, else grant next requester
//   ACCESS | present granted access; hold while buffer not ready
//   DONE   | pulse done, advance round-robin pointer
module spart_bus_arbiter
   import spart_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int GUARD_EN = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          br_cfg,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_rw,
   input  logic [2*NREQ-1:0]   req_addr,
   input  logic [8*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]     gnt,
   output logic                done,
   output logic [7:0]          rdata,
   output logic                cfg_busy,
   output logic                iocs,
   output logic                iorw,
   output logic [1:0]          ioaddr,
   input  logic                rda,
   input  logic                tbr,
   inout  wire  [7:0]          databus
);

   arb_state_t       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             done_q, done_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             cfg_busy_q, cfg_busy_d;
   logic             iocs_q, iocs_d;
   logic             iorw_q, iorw_d;
   logic [1:0]       ioaddr_q, ioaddr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [1:0]       cfg_q, cfg_d;
   logic [PTR_W-1:0] rr_q, rr_d;
   logic [PTR_W-1:0] gidx_q, gidx_d;

   logic [NREQ-1:0]  pick_gnt;
   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;
   logic             g_rw;
   logic [1:0]       g_addr;
   logic [7:0]       g_wdata;
   logic             stall;
   logic [15:0]      div_sel;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req_i   (req),
      .ptr_i   (rr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   // Encode the picker's one-hot grant as an index.
   always_comb begin
      pick_idx = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (pick_gnt[j]) pick_idx = PTR_W'(j);
      end
   end

   // Select the granted requester's access fields.
   always_comb begin
      g_rw    = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gidx_q == PTR_W'(j)) begin
            g_rw    = req_rw[j];
            g_addr  = req_addr[2*j +: 2];
            g_wdata = req_wdata[8*j +: 8];
         end
      end
   end

   // Only buffer accesses wait on the SPART handshakes.
   assign stall = (GUARD_EN != 0) && (g_addr == ADDR_BUF) && (g_rw ? !rda : !tbr);

   // High byte follows the live br_cfg (it is latched in the same cycle);
   // low byte must match what was latched.
   assign div_sel = div_for_cfg((state_q == CFG_HI) ? br_cfg : cfg_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = 1'b0;
      cfg_busy_d = cfg_busy_q;
      iocs_d     = 1'b0;
      iorw_d     = iorw_q;
      ioaddr_d   = ioaddr_q;
      wdata_d    = wdata_q;
      cfg_d      = cfg_q;
      rr_d       = rr_q;
      gidx_d     = gidx_q;
      // Capture read data at the end of the one chip-select cycle.
      rdata_d    = (iocs_q && iorw_q) ? databus : rdata_q;

      case (state_q)
         CFG_HI: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = ADDR_DBH;
            wdata_d    = div_sel[15:8];
            cfg_d      = br_cfg;
            cfg_busy_d = 1'b1;
            gnt_d      = '0;
            state_d    = CFG_LO;
         end
         CFG_LO: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = ADDR_DBL;
            wdata_d    = div_sel[7:0];
            cfg_busy_d = 1'b1;
            gnt_d      = '0;
            state_d    = IDLE;
         end
         IDLE: begin
            gnt_d = '0;
            if (br_cfg != cfg_q) begin
               cfg_busy_d = 1'b1;
               state_d    = CFG_HI;
            end else begin
               cfg_busy_d = 1'b0;
               if (pick_valid) begin
                  gnt_d   = pick_gnt;
                  gidx_d  = pick_idx;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            iorw_d   = g_rw;
            ioaddr_d = g_addr;
            if (!g_rw) wdata_d = g_wdata;
            if (!stall) begin
               iocs_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            rr_d    = (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + PTR_W'(1);
            state_d = IDLE;
         end
         default: begin
            state_d = CFG_HI;
         end
      endcase
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CFG_HI;
         gnt_q      <= '0;
         done_q     <= 1'b0;
         rdata_q    <= 8'h00;
         cfg_busy_q <= 1'b1;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b00;
         wdata_q    <= 8'h00;
         cfg_q      <= 2'b00;
         rr_q       <= '0;
         gidx_q     <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         cfg_busy_q <= cfg_busy_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         wdata_q    <= wdata_d;
         cfg_q      <= cfg_d;
         rr_q       <= rr_d;
         gidx_q     <= gidx_d;
      end
   end

   assign databus  = (iocs_q && !iorw_q) ? wdata_q : 8'bz;

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign cfg_busy = cfg_busy_q;
   assign iocs     = iocs_q;
   assign iorw     = iorw_q;
   assign ioaddr   = ioaddr_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter with a simple SPART read-data model.
module tb_spart_bus_arbiter;

   localparam int NREQ = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        br_cfg;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_rw;
   logic [2*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   gnt;
   logic              done;
   logic [7:0]        rdata;
   logic              cfg_busy;
   logic              iocs;
   logic              iorw;
   logic [1:0]        ioaddr;
   logic              rda;
   logic              tbr;
   wire  [7:0]        databus;
   logic [7:0]        sp_data;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   // SPART side: returns sp_data while a read is selected.
   assign databus = (iocs && iorw) ? sp_data : 8'bz;

   spart_bus_arbiter #(.NREQ(NREQ), .GUARD_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .br_cfg    (br_cfg),
      .req       (req),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .cfg_busy  (cfg_busy),
      .iocs      (iocs),
      .iorw      (iorw),
      .ioaddr    (ioaddr),
      .rda       (rda),
      .tbr       (tbr),
      .databus   (databus)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      br_cfg    = 2'b01;
      req       = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      rda       = 1'b0;
      tbr       = 1'b0;
      sp_data   = 8'h00;

      // Reset values
      tick();
      tick();
      chk("rst_gnt",      16'(gnt),      16'h0);
      chk("rst_done",     16'(done),     16'h0);
      chk("rst_rdata",    16'(rdata),    16'h00);
      chk("rst_cfg_busy", 16'(cfg_busy), 16'h1);
      chk("rst_iocs",     16'(iocs),     16'h0);
      chk("rst_iorw",     16'(iorw),     16'h1);
      chk("rst_ioaddr",   16'(ioaddr),   16'h0);
      rst = 1'b0;

      // Divisor programming for 9600 baud
      tick();
      chk("cfg1_iocs",   16'(iocs),     16'h1);
      chk("cfg1_iorw",   16'(iorw),     16'h0);
      chk("cfg1_ioaddr", 16'(ioaddr),   16'h3);
      chk("cfg1_data",   16'(databus),  16'h01);
      chk("cfg1_busy",   16'(cfg_busy), 16'h1);
      tick();
      chk("cfg2_iocs",   16'(iocs),     16'h1);
      chk("cfg2_ioaddr", 16'(ioaddr),   16'h2);
      chk("cfg2_data",   16'(databus),  16'h44);
      tick();
      chk("cfg3_busy",   16'(cfg_busy), 16'h0);
      chk("cfg3_iocs",   16'(iocs),     16'h0);
      chk("cfg3_gnt",    16'(gnt),      16'h0);

      // Requester 0 writes 0x41 to the TX buffer, stalled on tbr
      req       = 2'b01;
      req_rw    = 2'b00;
      req_addr  = 4'b0000;
      req_wdata = {8'h00, 8'h41};
      tick();
      chk("tx_gnt", 16'(gnt), 16'h1);
      chk("tx_iocs0", 16'(iocs), 16'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("tx_stall_iocs", 16'(iocs), 16'h0);
         chk("tx_stall_gnt",  16'(gnt),  16'h1);
         chk("tx_stall_done", 16'(done), 16'h0);
      end
      tbr = 1'b1;
      tick();
      chk("tx_iocs",   16'(iocs),    16'h1);
      chk("tx_iorw",   16'(iorw),    16'h0);
      chk("tx_ioaddr", 16'(ioaddr),  16'h0);
      chk("tx_data",   16'(databus), 16'h41);
      chk("tx_done0",  16'(done),    16'h0);
      tick();
      chk("tx_done",      16'(done), 16'h1);
      chk("tx_done_gnt",  16'(gnt),  16'h1);
      chk("tx_done_iocs", 16'(iocs), 16'h0);
      req = 2'b00;
      tick();
      chk("tx_gnt_fall", 16'(gnt),  16'h0);
      chk("tx_done_end", 16'(done), 16'h0);

      // Requester 1 reads the RX buffer; pointer now favours requester 1
      req      = 2'b10;
      req_rw   = 2'b10;
      req_addr = 4'b0000;
      rda      = 1'b1;
      sp_data  = 8'h5A;
      tick();
      chk("rx_gnt", 16'(gnt), 16'h2);
      tick();
      chk("rx_iocs", 16'(iocs), 16'h1);
      chk("rx_iorw", 16'(iorw), 16'h1);
      tick();
      chk("rx_done",  16'(done),  16'h1);
      chk("rx_rdata", 16'(rdata), 16'h5A);
      req = 2'b00;
      tick();
      chk("rx_gnt_fall", 16'(gnt), 16'h0);

      // Both requesters write the status register continuously
      req       = 2'b11;
      req_rw    = 2'b00;
      req_addr  = 4'b0101;
      req_wdata = {8'h11, 8'h10};
      for (int a = 0; a < 4; a++) begin
         tick();
         chk("rr_gnt",    16'(gnt),  16'(1 << (a % 2)));
         chk("rr_done_lo", 16'(done), 16'h0);
         tick();
         chk("rr_iocs",   16'(iocs),    16'h1);
         chk("rr_ioaddr", 16'(ioaddr),  16'h1);
         chk("rr_data",   16'(databus), 16'h10 + 16'(a % 2));
         chk("rr_done_lo2", 16'(done), 16'h0);
         tick();
         chk("rr_done",  16'(done),  16'h1);
         chk("rr_gnt_d", 16'(gnt),   16'(1 << (a % 2)));
         chk("rr_rdata", 16'(rdata), 16'h5A);
         if (a == 3) req = 2'b00;
      end
      tick();
      chk("rr_end_gnt", 16'(gnt), 16'h0);

      // br_cfg changes 01 -> 11 while a TX write is stalled
      req       = 2'b01;
      req_rw    = 2'b00;
      req_addr  = 4'b0000;
      req_wdata = {8'h00, 8'h77};
      tbr       = 1'b0;
      tick();
      chk("br_gnt", 16'(gnt), 16'h1);
      tick();
      chk("br_stall1", 16'(iocs), 16'h0);
      br_cfg = 2'b11;
      tick();
      chk("br_stall2", 16'(iocs),     16'h0);
      chk("br_busy0",  16'(cfg_busy), 16'h0);
      tbr = 1'b1;
      tick();
      chk("br_iocs", 16'(iocs),    16'h1);
      chk("br_data", 16'(databus), 16'h77);
      tick();
      chk("br_done", 16'(done), 16'h1);
      tick();
      chk("br_hi_gnt0", 16'(gnt),      16'h0);
      chk("br_hi_busy", 16'(cfg_busy), 16'h1);
      chk("br_hi_iocs", 16'(iocs),     16'h0);
      tick();
      chk("br_c1_iocs",   16'(iocs),    16'h1);
      chk("br_c1_ioaddr", 16'(ioaddr),  16'h3);
      chk("br_c1_data",   16'(databus), 16'h00);
      chk("br_c1_gnt",    16'(gnt),     16'h0);
      tick();
      chk("br_c2_ioaddr", 16'(ioaddr),  16'h2);
      chk("br_c2_data",   16'(databus), 16'h50);
      chk("br_c2_gnt",    16'(gnt),     16'h0);
      tick();
      chk("br_regnt",    16'(gnt),      16'h1);
      chk("br_busy_end", 16'(cfg_busy), 16'h0);

      // Reset in the middle of a driven write cycle
      tick();
      chk("ra_iocs", 16'(iocs),    16'h1);
      chk("ra_data", 16'(databus), 16'h77);
      rst = 1'b1;
      #1;
      chk("ra_rst_iocs", 16'(iocs),     16'h0);
      chk("ra_rst_gnt",  16'(gnt),      16'h0);
      chk("ra_rst_busy", 16'(cfg_busy), 16'h1);
      tick();
      rst = 1'b0;
      tick();
      chk("ra_c1_iocs",   16'(iocs),    16'h1);
      chk("ra_c1_ioaddr", 16'(ioaddr),  16'h3);
      chk("ra_c1_data",   16'(databus), 16'h00);
      chk("ra_c1_gnt",    16'(gnt),     16'h0);
      tick();
      chk("ra_c2_ioaddr", 16'(ioaddr),  16'h2);
      chk("ra_c2_data",   16'(databus), 16'h50);
      chk("ra_c2_gnt",    16'(gnt),     16'h0);
      tick();
      chk("ra_gnt",  16'(gnt),      16'h1);
      chk("ra_busy", 16'(cfg_busy), 16'h0);
      tick();
      chk("ra_iocs2", 16'(iocs),    16'h1);
      chk("ra_data2", 16'(databus), 16'h77);
      tick();
      chk("ra_done", 16'(done), 16'h1);
      req = 2'b00;
      tick();
      chk("ra_gnt_end", 16'(gnt), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spart_bus_arbiter.md
Name: spart_bus_arbiter

Overview:
- Owns the SPART processor-side bus (iocs/iorw/ioaddr/databus) and shares it between NREQ requesters, e.g. an echo driver and a status/debug poller.
- After reset, and whenever br_cfg changes, it programs the baud divisor (high byte, then low byte) before granting any requester.
- Round-robin arbitration, one bus access per grant.
- TX writes stall until tbr=1; RX reads of the data buffer stall until rda=1.

Parameters:
- NREQ, 2, number of requesters (2..4).
- GUARD_EN, 1, 1 = stall buffer accesses on tbr/rda; 0 = issue immediately.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- req  input  NREQ  per-requester access request; level, held until done.
- req_rw  input  NREQ  per requester: 1=read, 0=write.
- req_addr  input  2*NREQ  per-requester ioaddr, requester i at bits [2i+1:2i].
- req_wdata  input  8*NREQ  per-requester write data, requester i at bits [8i+7:8i].
- gnt  output  NREQ  one-hot grant, high for the whole granted access including stall.
- done  output  1  one-cycle pulse when the granted access completes.
- rdata  output  8  read data captured on a read completion; held until the next read completion.
- cfg_busy  output  1  high while divisor programming is in progress.
- iocs  output  1  SPART chip select.
- iorw  output  1  1=read, 0=write.
- ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- rda  input  1  SPART receive data available.
- tbr  input  1  SPART transmit buffer ready.
- databus  inout  8  driven only when iocs=1 and iorw=0; Z otherwise.

Behaviour:
- Reset values:
  - state = CFG_HI.
  - gnt = 0, done = 0, rdata = 8'h00, cfg_busy = 1, iocs = 0, iorw = 1, ioaddr = 2'b00.
  - rr pointer = 0; stored br_cfg = 2'b00.
- States: CFG_HI, CFG_LO, IDLE, ACCESS, DONE. All outputs are registered.
- CFG_HI:
  - Drives iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8].
  - Latches br_cfg. Always goes to CFG_LO.
- CFG_LO:
  - Drives iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0].
  - Goes to IDLE; cfg_busy falls on entry to IDLE.
- Divisor DIV, fixed for 50 MHz (clk/(16*baud) - 1): 4800 -> 0x028A, 9600 -> 0x0144, 19200 -> 0x00A1, 38400 -> 0x0050.
- IDLE:
  - If br_cfg differs from the latched value, go to CFG_HI with cfg_busy=1. This takes priority over pending requests.
  - Else if any req: pick the first requester at or after the rr pointer (wrapping modulo NREQ), assert its gnt, go to ACCESS.
  - iocs=0 in IDLE.
- ACCESS:
  - Drives iorw=req_rw[g] and ioaddr=req_addr[g]; databus=req_wdata[g] on writes.
  - Stall condition (only when GUARD_EN=1 and ioaddr=00): write needs tbr=0, read needs rda=0. While stalled, iocs=0 and the state holds.
  - Otherwise iocs=1 for exactly one cycle. On reads, rdata <= databus at the end of that cycle. Go to DONE.
  - Status (01) and divisor (10/11) accesses are never stalled.
- DONE:
  - done=1 for one cycle; gnt stays asserted this cycle, iocs=0.
  - rr pointer <= g+1 mod NREQ. Return to IDLE.
  - A requester still holding req is re-arbitrated fairly: minimum 3 cycles per access, IDLE -> ACCESS -> DONE.
- Requester rules:
  - req must not drop while gnt is high.
  - A requester dropping req in the DONE cycle is not regranted.
- br_cfg changes during ACCESS/DONE are deferred to the next IDLE. br_cfg changes during CFG_HI are ignored; CFG_LO still writes the low byte matching the latched value.
- Reset mid-access aborts immediately: bus released (iocs=0, databus Z), and divisor programming is restarted.
- Single driver of databus; never drives during reads or when iocs=0.

Decomposition:
- Package spart_pkg:
  - ioaddr constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11.
  - The four DIV constants and the function div_for_cfg(br_cfg) -> 16-bit.
  - State enum arb_state_t.
- Sub-module rr_picker: combinational round-robin selector. Inputs are req vector and pointer; outputs are one-hot grant and valid. It is the natural unit-test split.

Test Plan:
- Reset with br_cfg=01, release → cycle 1: iocs=1, iorw=0, ioaddr=11, databus=8'h01; cycle 2: ioaddr=10, databus=8'h44; then cfg_busy=0.
- req[0]=1 (write 8'h41, addr 00) with tbr=0 for 5 cycles, then tbr=1 → iocs stays 0 while stalled; one iocs write cycle with databus=8'h41; done pulse; gnt[0] falls after DONE.
- req=2'b11 held continuously for 4 accesses → grants alternate 0,1,0,1; exactly 4 done pulses, each 3 cycles apart.
- req[1] reads addr 00 with rda=1, SPART drives 8'h5A → rdata=8'h5A after done; rdata holds through a following write access.
- br_cfg changed 01→11 during an ACCESS stall → the access completes first, then CFG_HI/CFG_LO write 8'h00/8'h50 before the next grant.
- Assert rst during ACCESS write → iocs=0 and databus=Z in the same cycle; after release, divisor writes occur before any grant.
